// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

  // Defaults for a 50 MHz reference clock.
  localparam int unsigned DEF_RST_PULSE_CYC    = 16;      // 320 ns
  localparam int unsigned DEF_LOCK_STABLE_CYC  = 5000;    // 100 us
  localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 500000;  // 10 ms
  localparam int unsigned DEF_MAX_RETRY        = 3;
  localparam int unsigned DEF_CNT_W            = 20;

  // States in which the PLL is held in reset.
  function automatic logic holds_pll_in_reset(input pll_state_e s);
    return (s == ST_RESET_PLL) || (s == ST_FAULT);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level into the local clock.
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Capture flop followed by a settling flop; both clear on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Brings up the RX PLL: pulses its reset, waits for lock with timeout and
// bounded retries, qualifies lock stability, then releases sys_rst_n.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
  parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int unsigned MAX_RETRY        = DEF_MAX_RETRY,
  parameter int unsigned CNT_W            = DEF_CNT_W
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_cnt
);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic             restart;
  logic             lk_s;

  logic             pll_rst_q;
  logic             released_q;
  logic             fault_q;

  sync2 u_lock_sync (
    .clk_i  (refclk),
    .rst_ni (rst_n),
    .d_i    (pll_locked),
    .q_o    (lk_s)
  );

  // Next-state and retry bookkeeping; relock_req overrides every lock event.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    restart = 1'b0;
    if (relock_req) begin
      state_d = ST_RESET_PLL;
      restart = 1'b1;
      if (state_q == ST_FAULT) retry_d = '0;
    end else begin
      case (state_q)
        ST_RESET_PLL: begin
          if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lk_s) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAULT;
            end else begin
              retry_d = retry_q + 2'd1;
              state_d = ST_RESET_PLL;
            end
          end
        end
        ST_STABLE: begin
          if (!lk_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          if (!lk_s) state_d = ST_RESET_PLL;
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_RESET_PLL;
        end
      endcase
    end
  end

  // Shared cycle counter: clears on any state change or relock restart,
  // and only runs in the timed states so it never wraps in RUN/FAULT.
  always_comb begin
    cnt_d = cnt_q;
    if (restart || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (state_q inside {ST_RESET_PLL, ST_WAIT_LOCK, ST_STABLE}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, counter and retry registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET_PLL;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  // Registered outputs. Release waits until RUN has been held for one
  // registered cycle, while re-entering reset on leaving RUN is immediate.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst_q  <= 1'b1;
      released_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      pll_rst_q  <= holds_pll_in_reset(state_d);
      released_q <= (state_q == ST_RUN) && (state_d == ST_RUN);
      fault_q    <= (state_d == ST_FAULT);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = released_q;
  assign ready     = released_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

endmodule
